// File: rtl/ceil_div_seq_pkg.sv
// ------------------------------------------------------------------
// ceil_div_seq_pkg : state type and counter sizing for ceil_div_seq
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package ceil_div_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bits needed to index num items, never less than one.
  function automatic int unsigned idx_width(input int unsigned num);
    return (num > 32'd1) ? unsigned'($clog2(num)) : 32'd1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned width);
    return idx_width(width);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ceil_div_step.sv
// ------------------------------------------------------------------
// ceil_div_step : one combinational restoring-division step
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module ceil_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             bit_i,
  output logic [WIDTH:0]   rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0]   shifted_lo;
  logic [WIDTH+1:0] diff;
  logic             geq;

  // A set top bit means the shifted value already exceeds any divisor;
  // the low-bit difference is still correct modulo 2^(WIDTH+1).
  always_comb begin
    shifted_lo = {rem_i[WIDTH-1:0], bit_i};
    diff       = {1'b0, shifted_lo} - {2'b00, divisor_i};
    geq        = rem_i[WIDTH] | ~diff[WIDTH+1];
    rem_o      = geq ? diff[WIDTH:0] : shifted_lo;
    q_bit_o    = geq;
  end

endmodule

`default_nettype wire

// File: rtl/ceil_div_seq.sv
// ------------------------------------------------------------------
// ceil_div_seq : multi-cycle unsigned ceiling divider, valid/ready
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module ceil_div_seq
  import ceil_div_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_zero_o
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_zero_q, div_zero_d;

  logic [WIDTH:0]   step_rem;
  logic             step_bit;
  logic             accept;
  logic [WIDTH-1:0] floor_q;

  ceil_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .divisor_i (dvs_q),
    .bit_i     (dvd_q[WIDTH-1]),
    .rem_o     (step_rem),
    .q_bit_o   (step_bit)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (in_valid_i) state_d = (divisor_i == '0) ? DONE : CALC;
        CALC:    if (cnt_q == '0) state_d = DONE;
        DONE:    if (out_ready_i) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready_o  = (state_q == IDLE);
    out_valid_o = (state_q == DONE);
  end

  // The dividend register shifts out dividend bits MSB first and shifts
  // quotient bits in at the bottom, so it ends up holding the floor quotient.
  always_comb begin
    accept      = in_valid_i && in_ready_o && !flush_i;
    floor_q     = {dvd_q[WIDTH-2:0], step_bit};
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
    if (accept) begin
      dvd_d = dividend_i;
      dvs_d = divisor_i;
      rem_d = '0;
      cnt_d = CNT_W'(WIDTH - 1);
      if (divisor_i == '0) begin
        quotient_d  = '1;
        remainder_d = dividend_i;
        div_zero_d  = 1'b1;
      end
    end else if (state_q == CALC && !flush_i) begin
      rem_d = step_rem;
      dvd_d = floor_q;
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == '0) begin
        // Cannot wrap: divisor 1 leaves no remainder, divisor >= 2 halves the range.
        quotient_d  = floor_q + WIDTH'(step_rem != '0);
        remainder_d = step_rem[WIDTH-1:0];
        div_zero_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q       <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
    end
  end

  assign quotient_o  = quotient_q;
  assign remainder_o = remainder_q;
  assign div_zero_o  = div_zero_q;

`ifndef SYNTHESIS
  logic [WIDTH-1:0]   chk_dvd_q;
  logic [WIDTH-1:0]   chk_dvs_q;
  logic [2*WIDTH-1:0] chk_prod;
  logic [2*WIDTH-1:0] chk_prod_m1;

  always_ff @(posedge clk_i) begin
    if (accept) begin
      chk_dvd_q <= dividend_i;
      chk_dvs_q <= divisor_i;
    end
  end

  always_comb begin
    chk_prod    = (2*WIDTH)'(quotient_o) * (2*WIDTH)'(chk_dvs_q);
    chk_prod_m1 = (2*WIDTH)'(quotient_o - WIDTH'(1)) * (2*WIDTH)'(chk_dvs_q);
  end

  a_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (out_valid_o && !out_ready_i && !flush_i) |=>
      (out_valid_o && $stable(quotient_o) && $stable(remainder_o) && $stable(div_zero_o)));

  a_ceil_upper: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (out_valid_o && !div_zero_o) |-> (chk_prod >= (2*WIDTH)'(chk_dvd_q)));

  a_ceil_lower: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (out_valid_o && !div_zero_o && chk_dvd_q != '0) |-> (chk_prod_m1 < (2*WIDTH)'(chk_dvd_q)));
`endif

endmodule

`default_nettype wire

// File: tb/tb_ceil_div_seq.sv
// ------------------------------------------------------------------
// tb_ceil_div_seq : scoreboard bench for ceil_div_seq
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_ceil_div_seq;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           lat;
    int           hold;
    int           acc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_ni;
  logic         flush_i;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [W-1:0] dividend_i;
  logic [W-1:0] divisor_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [W-1:0] quotient_o;
  logic [W-1:0] remainder_o;
  logic         div_zero_o;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   mon_busy = 1'b0;

  ceil_div_seq #(.WIDTH(W)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .quotient_o  (quotient_o),
    .remainder_o (remainder_o),
    .div_zero_o  (div_zero_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eq, input logic [W-1:0] er,
                       input logic ez, input int hold, input bit push);
    bit   ok;
    exp_t e;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (in_ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check("req_timeout", 64'd0, 64'd1);
      return;
    end
    in_valid_i = 1'b1;
    dividend_i = a;
    divisor_i  = b;
    if (push) begin
      e.q    = eq;
      e.r    = er;
      e.z    = ez;
      e.lat  = ez ? 1 : W + 1;
      e.hold = hold;
      e.acc  = cyc;
      sb.push_back(e);
    end
    @(posedge clk);
    #1 in_valid_i = 1'b0;
  endtask

  task automatic issue_model(input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
    logic [W-1:0] q;
    logic [W-1:0] r;
    if (b == '0) begin
      issue(a, b, '1, a, 1'b1, hold, 1'b1);
    end else begin
      r = a % b;
      q = a / b + ((r != '0) ? 32'd1 : 32'd0);
      issue(a, b, q, r, 1'b0, hold, 1'b1);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !mon_busy) break;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: owns out_ready_i, pops the scoreboard on every presented result.
  initial begin
    exp_t e;
    out_ready_i = 1'b1;
    forever begin
      @(negedge clk);
      if (out_valid_o) begin
        if (sb.size() == 0) begin
          check("unexpected_out", 64'(out_valid_o), 64'd0);
        end else begin
          mon_busy = 1'b1;
          e = sb.pop_front();
          check("latency", 64'(cyc - e.acc), 64'(e.lat));
          check("quotient", 64'(quotient_o), 64'(e.q));
          check("remainder", 64'(remainder_o), 64'(e.r));
          check("div_zero", 64'(div_zero_o), 64'(e.z));
          if (e.hold > 0) begin
            out_ready_i = 1'b0;
            for (int h = 0; h < e.hold; h++) begin
              @(negedge clk);
              check("hold_valid", 64'(out_valid_o), 64'd1);
              check("hold_q", 64'(quotient_o), 64'(e.q));
              check("hold_r", 64'(remainder_o), 64'(e.r));
              check("hold_in_ready", 64'(in_ready_o), 64'd0);
            end
            out_ready_i = 1'b1;
            @(negedge clk);
            check("release_valid", 64'(out_valid_o), 64'd0);
            check("release_in_ready", 64'(in_ready_o), 64'd1);
          end
          mon_busy = 1'b0;
        end
      end
    end
  end

  initial begin
    rst_ni     = 1'b0;
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    dividend_i = '0;
    divisor_i  = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(in_ready_o), 64'd1);
    check("rst_out_valid", 64'(out_valid_o), 64'd0);
    check("rst_quotient", 64'(quotient_o), 64'd0);
    check("rst_remainder", 64'(remainder_o), 64'd0);
    check("rst_div_zero", 64'(div_zero_o), 64'd0);
    rst_ni = 1'b1;

    issue(32'd100, 32'd7, 32'd15, 32'd2, 1'b0, 0, 1'b1);
    issue(32'd84, 32'd7, 32'd12, 32'd0, 1'b0, 0, 1'b1);
    issue(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 0, 1'b1);
    issue(32'hFFFF_FFFF, 32'd2, 32'h8000_0000, 32'd1, 1'b0, 0, 1'b1);
    issue(32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 0, 1'b1);
    issue(32'd37, 32'd0, 32'hFFFF_FFFF, 32'd37, 1'b1, 0, 1'b1);
    issue(32'd1000, 32'd3, 32'd334, 32'd1, 1'b0, 10, 1'b1);
    issue(32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 3, 1'b1);
    drain();

    // Flush mid-calculation: nothing is delivered.
    issue(32'd500, 32'd9, '0, '0, 1'b0, 0, 1'b0);
    repeat (10) @(negedge clk);
    flush_i = 1'b1;
    @(posedge clk);
    #1 flush_i = 1'b0;
    check("flush_in_ready", 64'(in_ready_o), 64'd1);
    check("flush_out_valid", 64'(out_valid_o), 64'd0);

    // Request offered together with flush in IDLE must be ignored.
    @(negedge clk);
    flush_i    = 1'b1;
    in_valid_i = 1'b1;
    dividend_i = 32'd50;
    divisor_i  = 32'd5;
    @(posedge clk);
    #1;
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    check("flush_void_req", 64'(in_ready_o), 64'd1);
    repeat (W + 4) @(negedge clk);
    issue(32'd18, 32'd4, 32'd5, 32'd2, 1'b0, 0, 1'b1);
    drain();

    // Reset mid-operation.
    issue(32'd100, 32'd7, '0, '0, 1'b0, 0, 1'b0);
    repeat (5) @(negedge clk);
    rst_ni = 1'b0;
    #1;
    check("midrst_in_ready", 64'(in_ready_o), 64'd1);
    check("midrst_out_valid", 64'(out_valid_o), 64'd0);
    check("midrst_quotient", 64'(quotient_o), 64'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    repeat (W + 8) @(negedge clk);
    check("no_stale_out", 64'(out_valid_o), 64'd0);

    for (int k = 0; k < 150; k++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = $urandom_range(0, 5);
        1:       b = $urandom_range(1, 1000);
        default: b = $urandom;
      endcase
      issue_model(a, b, $urandom_range(0, 3));
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: actual=timeout required=finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
